// File: rtl/mips_pkg.sv
// Shared types and constants for the MEM-stage SRAM bridge: FSM states,
// external SRAM geometry and the byte-address to word-index mapping.
package mips_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOW,
      HIGH,
      DONE
   } state_t;

   localparam int SRAM_DW           = 16;
   localparam int SRAM_AW           = 18;
   localparam int WIDX_W            = SRAM_AW - 1;
   localparam int DEFAULT_BASE_ADDR = 1024;

   // Word index inside the SRAM; wraps modulo 128K words.
   function automatic logic [WIDX_W-1:0] word_index(input logic [31:0] address,
                                                    input logic [31:0] base);
      return WIDX_W'((address - base) >> 2);
   endfunction

endpackage

// File: rtl/sram_rdbuf.sv
// One-entry read buffer {valid, widx, data} for mem_sram_ctrl, only
// instantiated when MEM_SRAM_RDBUF_EN is defined.
module sram_rdbuf
   import mips_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDX_W-1:0]      lookup_widx,
   output logic                   hit,
   output logic [2*SRAM_DW-1:0]   data,
   input  logic                   fill,
   input  logic [WIDX_W-1:0]      fill_widx,
   input  logic [2*SRAM_DW-1:0]   fill_data,
   input  logic                   update,
   input  logic [2*SRAM_DW-1:0]   update_data
);

   logic                 valid;
   logic [WIDX_W-1:0]    tag;
   logic [2*SRAM_DW-1:0] data_q;

   assign hit  = valid && (tag == lookup_widx);
   assign data = data_q;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
      end else if (fill) begin
         valid <= 1'b1;
      end
   end

   // NOTE: tag and data need no reset; valid alone gates their use, which
   // keeps reset fan-out off the storage bits.
   always_ff @(posedge clk) begin
      if (fill) begin
         tag    <= fill_widx;
         data_q <= fill_data;
      end else if (update && hit) begin
         data_q <= update_data;
      end
   end

endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage bridge to a 256K x 16 asynchronous SRAM: each 32-bit access is two
// half-word phases (low, then high). Optional read buffer: MEM_SRAM_RDBUF_EN.
module mem_sram_ctrl
   import mips_pkg::*;
#(
   parameter int BASE_ADDR     = DEFAULT_BASE_ADDR,
   parameter int ACCESS_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   read,
   input  logic                   write,
   input  logic [31:0]            address,
   input  logic [31:0]            writedata,
   output logic [31:0]            readdata,
   output logic                   ready,
   output logic [SRAM_AW-1:0]     SRAM_ADDR,
   inout  wire  [SRAM_DW-1:0]     SRAM_DQ,
   output logic                   SRAM_WE_N,
   output logic                   SRAM_OE_N,
   output logic                   SRAM_CE_N,
   output logic                   SRAM_UB_N,
   output logic                   SRAM_LB_N
);

   localparam int CW = $clog2(ACCESS_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [CW-1:0]        cnt_next;
   logic                 op_write;
   logic [WIDX_W-1:0]    widx_q;
   logic [31:0]          wdata_q;
   logic [SRAM_DW-1:0]   dq_out;
   logic                 dq_oe;
   logic                 req;
   logic [WIDX_W-1:0]    widx_in;
   logic                 buf_hit;
   logic [31:0]          buf_data;

   assign req      = read | write;
   assign widx_in  = word_index(address, 32'(BASE_ADDR));
   assign cnt_next = cnt + CW'(1);
   assign ready    = ~(req & (state != DONE));
   assign SRAM_DQ  = dq_oe ? dq_out : {SRAM_DW{1'bz}};

`ifdef MEM_SRAM_RDBUF_EN
   logic fill_en;
   logic update_en;

   assign fill_en   = (state == HIGH) && (cnt == LAST) && !op_write;
   assign update_en = (state == IDLE) && write;

   sram_rdbuf u_rdbuf (
      .clk         (clk),
      .rst         (rst),
      .lookup_widx (widx_in),
      .hit         (buf_hit),
      .data        (buf_data),
      .fill        (fill_en),
      .fill_widx   (widx_q),
      .fill_data   ({SRAM_DQ, readdata[SRAM_DW-1:0]}),
      .update      (update_en),
      .update_data (writedata)
   );
`else
   assign buf_hit  = 1'b0;
   assign buf_data = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         op_write  <= 1'b0;
         widx_q    <= '0;
         wdata_q   <= '0;
         readdata  <= '0;
         SRAM_ADDR <= '0;
         SRAM_WE_N <= 1'b1;
         SRAM_OE_N <= 1'b1;
         SRAM_CE_N <= 1'b1;
         SRAM_UB_N <= 1'b1;
         SRAM_LB_N <= 1'b1;
         dq_oe     <= 1'b0;
         dq_out    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req) begin
                  op_write <= write;
                  widx_q   <= widx_in;
                  wdata_q  <= writedata;
                  cnt      <= '0;
                  if (!write && buf_hit) begin
                     state    <= DONE;
                     readdata <= buf_data;
                  end else begin
                     state     <= LOW;
                     SRAM_ADDR <= {widx_in, 1'b0};
                     SRAM_CE_N <= 1'b0;
                     SRAM_UB_N <= 1'b0;
                     SRAM_LB_N <= 1'b0;
                     SRAM_OE_N <= write;
                     SRAM_WE_N <= ~write;
                     dq_oe     <= write;
                     dq_out    <= writedata[SRAM_DW-1:0];
                  end
               end
            end
            LOW, HIGH: begin
               if (cnt == LAST) begin
                  cnt <= '0;
                  if (state == LOW) begin
                     if (!op_write) readdata[SRAM_DW-1:0] <= SRAM_DQ;
                     state     <= HIGH;
                     SRAM_ADDR <= {widx_q, 1'b1};
                     SRAM_WE_N <= ~op_write;
                     dq_out    <= wdata_q[2*SRAM_DW-1:SRAM_DW];
                  end else begin
                     if (!op_write) readdata[2*SRAM_DW-1:SRAM_DW] <= SRAM_DQ;
                     state     <= DONE;
                     SRAM_CE_N <= 1'b1;
                     SRAM_UB_N <= 1'b1;
                     SRAM_LB_N <= 1'b1;
                     SRAM_OE_N <= 1'b1;
                     SRAM_WE_N <= 1'b1;
                     dq_oe     <= 1'b0;
                  end
               end else begin
                  // WE_N rises on the last phase cycle while data is still driven.
                  cnt       <= cnt_next;
                  SRAM_WE_N <= ~(op_write && (cnt_next != LAST));
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Scoreboard bench for mem_sram_ctrl against a behavioural 256K x 16 SRAM;
// read-buffer vectors are selected by MEM_SRAM_RDBUF_EN.
module tb_mem_sram_ctrl;

   typedef struct {
      logic [31:0] data;
      int          stalls;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        read;
   logic        write;
   logic [31:0] address;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        ready;
   logic [17:0] SRAM_ADDR;
   wire  [15:0] SRAM_DQ;
   logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

   logic [15:0] mem [0:262143];
   exp_t        exp_q[$];
   logic [17:0] addr_log[$];
   int          ce_cnt, oe_cnt, we_cnt, n_done;
   int          vectors, miscompares;

   always #5 clk = ~clk;

   mem_sram_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .read      (read),
      .write     (write),
      .address   (address),
      .writedata (writedata),
      .readdata  (readdata),
      .ready     (ready),
      .SRAM_ADDR (SRAM_ADDR),
      .SRAM_DQ   (SRAM_DQ),
      .SRAM_WE_N (SRAM_WE_N),
      .SRAM_OE_N (SRAM_OE_N),
      .SRAM_CE_N (SRAM_CE_N),
      .SRAM_UB_N (SRAM_UB_N),
      .SRAM_LB_N (SRAM_LB_N)
   );

   // Behavioural asynchronous SRAM.
   assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR] : 16'hzzzz;

   always @(negedge clk) begin
      if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: pops one expectation per completion (request seen with ready high).
   task automatic run_monitor();
      int stalls = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst || !(read || write)) begin
            stalls = 0;
         end else if (ready) begin
            n_done++;
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_completion: actual readdata %h required none", readdata);
            end else begin
               e = exp_q.pop_front();
               check("readdata", readdata, e.data);
               check("stall_cycles", 32'(stalls), 32'(e.stalls));
            end
            stalls = 0;
         end else begin
            stalls++;
         end
      end
   endtask

   // Records each distinct SRAM address per chip-enable window and counts strobes.
   task automatic run_logger();
      logic        ce_prev = 1'b0;
      logic [17:0] last_addr = '0;
      forever begin
         @(negedge clk);
         if (!SRAM_CE_N) begin
            if (!ce_prev || SRAM_ADDR != last_addr) addr_log.push_back(SRAM_ADDR);
            ce_cnt++;
            if (!SRAM_OE_N) oe_cnt++;
            if (!SRAM_WE_N) we_cnt++;
         end
         ce_prev   = !SRAM_CE_N;
         last_addr = SRAM_ADDR;
      end
   endtask

   // Issues one request at the current cycle and holds it until ready.
   task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_data,
                         input int exp_stalls);
      logic got = 1'b0;
      exp_q.push_back('{exp_data, exp_stalls});
      read      = rd;
      write     = wr;
      address   = addr;
      writedata = wd;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         check("access_timeout", 32'(got), 32'd1);
         exp_q.delete();
      end
      @(posedge clk);
      #1;
      read  = 1'b0;
      write = 1'b0;
   endtask

   task automatic check_addr(input string name, input int idx, input logic [17:0] exp);
      if (idx < addr_log.size()) check(name, 32'(addr_log[idx]), 32'(exp));
      else check(name, 32'hFFFF_FFFF, 32'(exp));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lb, ce0, oe0, we0, d0;
      vectors = 0; miscompares = 0;
      ce_cnt = 0; oe_cnt = 0; we_cnt = 0; n_done = 0;
      rst = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
      fork
         run_monitor();
         run_logger();
      join_none

      repeat (3) @(posedge clk);
      #1;
      check("reset_readdata", readdata, 32'h0);
      check("reset_ctrls", {27'b0, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 32'h1F);
      check("reset_addr", 32'(SRAM_ADDR), 32'h0);
      check("reset_ready", 32'(ready), 32'h1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Store then load at the base address.
      lb = addr_log.size(); ce0 = ce_cnt; we0 = we_cnt;
      access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0, 5);
      check("store_addr_count", 32'(addr_log.size() - lb), 32'd2);
      check_addr("store_addr_lo", lb, 18'h0);
      check_addr("store_addr_hi", lb + 1, 18'h1);
      check("store_mem_lo", 32'(mem[0]), 32'hBEEF);
      check("store_mem_hi", 32'(mem[1]), 32'hDEAD);
      check("store_we_cycles", 32'(we_cnt - we0), 32'd2);
      check("store_ce_cycles", 32'(ce_cnt - ce0), 32'd4);
      access(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 5);

      // Address below the base wraps to the top of the SRAM.
      lb = addr_log.size();
      access(1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 32'hDEADBEEF, 5);
      check_addr("wrap_addr_lo", lb, 18'h3FFFE);
      check_addr("wrap_addr_hi", lb + 1, 18'h3FFFF);
      check("wrap_mem_lo", 32'(mem[18'h3FFFE]), 32'hF00D);
      access(1'b1, 1'b0, 32'd1020, 32'h0, 32'hCAFEF00D, 5);

      // Back-to-back loads with no idle gap between requests.
      access(1'b0, 1'b1, 32'd1028, 32'h22221111, 32'hCAFEF00D, 5);
      access(1'b0, 1'b1, 32'd1032, 32'h44443333, 32'hCAFEF00D, 5);
      lb = addr_log.size(); d0 = n_done;
      access(1'b1, 1'b0, 32'd1028, 32'h0, 32'h22221111, 5);
      access(1'b1, 1'b0, 32'd1032, 32'h0, 32'h44443333, 5);
      check("b2b_completions", 32'(n_done - d0), 32'd2);
      check_addr("b2b_addr0", lb, 18'h2);
      check_addr("b2b_addr1", lb + 1, 18'h3);
      check_addr("b2b_addr2", lb + 2, 18'h4);
      check_addr("b2b_addr3", lb + 3, 18'h5);

      // read and write together behave as a store.
      oe0 = oe_cnt; we0 = we_cnt;
      access(1'b1, 1'b1, 32'd1036, 32'h55AA66BB, 32'h44443333, 5);
      check("rw_oe_cycles", 32'(oe_cnt - oe0), 32'd0);
      check("rw_we_cycles", 32'(we_cnt - we0), 32'd2);
      check("rw_mem_lo", 32'(mem[6]), 32'h66BB);
      check("rw_mem_hi", 32'(mem[7]), 32'h55AA);

      // Reset during the high phase of a store aborts it.
      address = 32'd1040; writedata = 32'h0BADCAFE; write = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("abort_high_addr", 32'(SRAM_ADDR), 32'h9);
      check("abort_high_ce", 32'(SRAM_CE_N), 32'h0);
      rst = 1'b1; write = 1'b0;
      @(posedge clk);
      #1;
      check("abort_we", 32'(SRAM_WE_N), 32'h1);
      check("abort_ce", 32'(SRAM_CE_N), 32'h1);
      check("abort_readdata", readdata, 32'h0);
      check("abort_ready", 32'(ready), 32'h1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      access(1'b0, 1'b1, 32'd1040, 32'h0BADCAFE, 32'h0, 5);

`ifdef MEM_SRAM_RDBUF_EN
      access(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 5);
      ce0 = ce_cnt;
      access(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 1);
      check("rdbuf_hit_ce", 32'(ce_cnt - ce0), 32'd0);
      access(1'b0, 1'b1, 32'd1024, 32'h12345678, 32'hDEADBEEF, 5);
      ce0 = ce_cnt;
      access(1'b1, 1'b0, 32'd1024, 32'h0, 32'h12345678, 1);
      check("rdbuf_upd_ce", 32'(ce_cnt - ce0), 32'd0);
`else
      ce0 = ce_cnt;
      access(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 5);
      check("reread_ce", 32'(ce_cnt - ce0), 32'd4);
`endif

      repeat (4) @(posedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
